// File: rtl/relock_pkg.sv
// Shared state encoding for the relock detector and the LED indicator stage.
package relock_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StLocked  = 2'd1,
        StSearch  = 2'd2,
        StCapture = 2'd3
    } relock_state_e;

    localparam logic [1:0] IdleCode    = 2'd0;
    localparam logic [1:0] LockedCode  = 2'd1;
    localparam logic [1:0] SearchCode  = 2'd2;
    localparam logic [1:0] CaptureCode = 2'd3;

endpackage

// File: rtl/relock_ramp.sv
// Triangle sweep generator: steps by `step` toward the active limit, clamps and reverses there.
module relock_ramp #(
    parameter int unsigned W = 16
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         run,
    input  logic         hold,
    input  logic [W-1:0] step,
    input  logic [W-1:0] ramp_min,
    input  logic [W-1:0] ramp_max,
    output logic [W-1:0] ramp
);

    // Two guard bits so a full-scale unsigned step added to any signed value cannot overflow.
    localparam int unsigned SW = W + 2;

    logic [W-1:0]         ramp_q, ramp_d;
    logic                 down_q, down_d;
    logic signed [SW-1:0] cur, stp, mn, mx, sum;

    assign cur = {{2{ramp_q[W-1]}}, ramp_q};
    assign stp = {2'b00, step};
    assign mn  = {{2{ramp_min[W-1]}}, ramp_min};
    assign mx  = {{2{ramp_max[W-1]}}, ramp_max};
    assign sum = down_q ? (cur - stp) : (cur + stp);

    always_comb begin
        ramp_d = ramp_q;
        down_d = down_q;
        if (run && !hold) begin
            if (mn >= mx) begin
                ramp_d = ramp_min;
            end else if (sum >= mx) begin
                ramp_d = ramp_max;
                down_d = 1'b1;
            end else if (sum <= mn) begin
                ramp_d = ramp_min;
                down_d = 1'b0;
            end else begin
                ramp_d = sum[W-1:0];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            ramp_q <= '0;
            down_q <= 1'b0;
        end else begin
            ramp_q <= ramp_d;
            down_q <= down_d;
        end
    end

    assign ramp = ramp_q;

endmodule

// File: rtl/relock_detector.sv
// Lock-loss detector: hysteresis compare with debounce, sweeps the actuator offset while unlocked.
module relock_detector
    import relock_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned CNT_W = 24
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [W-1:0]     sig_in,
    input  logic [W-1:0]     thr_lo,
    input  logic [W-1:0]     thr_hi,
    input  logic [CNT_W-1:0] t_unlock,
    input  logic [CNT_W-1:0] t_lock,
    input  logic [W-1:0]     ramp_step,
    input  logic [W-1:0]     ramp_min,
    input  logic [W-1:0]     ramp_max,
    output logic             relock_on,
    output logic [W-1:0]     ramp_out,
    output logic [1:0]       state_out
);

    relock_state_e    state_q, state_d;
    logic [CNT_W-1:0] lo_q, lo_d, hi_q, hi_d;
    logic             relock_q, relock_d;

    logic             sig_low, sig_high;
    logic [CNT_W-1:0] t_unlock_eff, t_lock_eff, lo_inc, hi_inc;
    logic             unlock_hit, lock_hit, lock_on_entry;

    assign sig_low  = $signed(sig_in) < $signed(thr_lo);
    assign sig_high = $signed(sig_in) > $signed(thr_hi);

    assign t_unlock_eff = (t_unlock == '0) ? CNT_W'(1) : t_unlock;
    assign t_lock_eff   = (t_lock == '0) ? CNT_W'(1) : t_lock;

    // Saturating increments; the compare uses one extra bit so lo_q+1 never wraps.
    assign lo_inc = (&lo_q) ? lo_q : lo_q + CNT_W'(1);
    assign hi_inc = (&hi_q) ? hi_q : hi_q + CNT_W'(1);
    assign unlock_hit    = ({1'b0, lo_q} + (CNT_W + 1)'(1)) >= {1'b0, t_unlock_eff};
    assign lock_hit      = ({1'b0, hi_q} + (CNT_W + 1)'(1)) >= {1'b0, t_lock_eff};
    // The sample that leaves SEARCH is the first high sample, so t_lock<=1 locks immediately.
    assign lock_on_entry = (t_lock_eff == CNT_W'(1));

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        if (!enable) begin
            state_d = StIdle;
            lo_d    = '0;
            hi_d    = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StLocked;
                    lo_d    = '0;
                    hi_d    = '0;
                end
                StLocked: begin
                    hi_d = '0;
                    if (sig_low) begin
                        if (unlock_hit) begin
                            state_d = StSearch;
                            lo_d    = '0;
                        end else begin
                            lo_d = lo_inc;
                        end
                    end else begin
                        lo_d = '0;
                    end
                end
                StSearch: begin
                    lo_d = '0;
                    hi_d = '0;
                    if (sig_high) begin
                        if (lock_on_entry) begin
                            state_d = StLocked;
                        end else begin
                            state_d = StCapture;
                            hi_d    = CNT_W'(1);
                        end
                    end
                end
                StCapture: begin
                    lo_d = '0;
                    if (sig_high) begin
                        if (lock_hit) begin
                            state_d = StLocked;
                            hi_d    = '0;
                        end else begin
                            hi_d = hi_inc;
                        end
                    end else begin
                        state_d = StSearch;
                        hi_d    = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    lo_d    = '0;
                    hi_d    = '0;
                end
            endcase
        end
    end

    assign relock_d = (state_d == StSearch) || (state_d == StCapture);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            lo_q     <= '0;
            hi_q     <= '0;
            relock_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            relock_q <= relock_d;
        end
    end

    relock_ramp #(
        .W(W)
    ) u_ramp (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .run      (enable && (state_q == StSearch)),
        .hold     (sig_high),
        .step     (ramp_step),
        .ramp_min (ramp_min),
        .ramp_max (ramp_max),
        .ramp     (ramp_out)
    );

    assign relock_on = relock_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_relock_detector.sv
// Directed bench for relock_detector: vector table plus reset, zero-threshold and pinned-ramp cases.
module tb_relock_detector;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] sig_in, thr_lo, thr_hi, ramp_step, ramp_min, ramp_max;
    logic [23:0] t_unlock, t_lock;
    logic        relock_on;
    logic [15:0] ramp_out;
    logic [1:0]  state_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic en;
        int   sig;
        int   st;
        logic rl;
        int   rp;
    } vec_t;

    vec_t vecs[36];

    relock_detector dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .enable    (enable),
        .sig_in    (sig_in),
        .thr_lo    (thr_lo),
        .thr_hi    (thr_hi),
        .t_unlock  (t_unlock),
        .t_lock    (t_lock),
        .ramp_step (ramp_step),
        .ramp_min  (ramp_min),
        .ramp_max  (ramp_max),
        .relock_on (relock_on),
        .ramp_out  (ramp_out),
        .state_out (state_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input int st, input int rl, input int rp);
        check({tag, " state"}, int'(state_out), st);
        check({tag, " relock"}, int'(relock_on), rl);
        check({tag, " ramp"}, int'($signed(ramp_out)), rp);
    endtask

    task automatic step_edge(input int sig);
        sig_in = sig[15:0];
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        // Config: thr 200/600, t_unlock 3, t_lock 4, step 300, range [-1000, 1000].
        vecs[0]  = '{1'b1, 1000, 1, 1'b0, 0};
        vecs[1]  = '{1'b1, 100, 1, 1'b0, 0};
        vecs[2]  = '{1'b1, 100, 1, 1'b0, 0};
        vecs[3]  = '{1'b1, 1000, 1, 1'b0, 0};
        vecs[4]  = '{1'b1, 100, 1, 1'b0, 0};
        vecs[5]  = '{1'b1, 100, 1, 1'b0, 0};
        vecs[6]  = '{1'b1, 100, 2, 1'b1, 0};
        vecs[7]  = '{1'b1, 100, 2, 1'b1, 300};
        vecs[8]  = '{1'b1, 100, 2, 1'b1, 600};
        vecs[9]  = '{1'b1, 100, 2, 1'b1, 900};
        vecs[10] = '{1'b1, 100, 2, 1'b1, 1000};
        vecs[11] = '{1'b1, 100, 2, 1'b1, 700};
        vecs[12] = '{1'b1, 100, 2, 1'b1, 400};
        vecs[13] = '{1'b1, 100, 2, 1'b1, 100};
        vecs[14] = '{1'b1, 100, 2, 1'b1, -200};
        vecs[15] = '{1'b1, 100, 2, 1'b1, -500};
        vecs[16] = '{1'b1, 100, 2, 1'b1, -800};
        vecs[17] = '{1'b1, 100, 2, 1'b1, -1000};
        vecs[18] = '{1'b1, 100, 2, 1'b1, -700};
        vecs[19] = '{1'b1, 800, 3, 1'b1, -700};
        vecs[20] = '{1'b1, 800, 3, 1'b1, -700};
        vecs[21] = '{1'b1, 500, 2, 1'b1, -700};
        vecs[22] = '{1'b1, 500, 2, 1'b1, -400};
        vecs[23] = '{1'b1, 800, 3, 1'b1, -400};
        vecs[24] = '{1'b1, 800, 3, 1'b1, -400};
        vecs[25] = '{1'b1, 800, 3, 1'b1, -400};
        vecs[26] = '{1'b1, 800, 1, 1'b0, -400};
        vecs[27] = '{1'b1, 800, 1, 1'b0, -400};
        vecs[28] = '{1'b1, 100, 1, 1'b0, -400};
        vecs[29] = '{1'b1, 100, 1, 1'b0, -400};
        vecs[30] = '{1'b1, 100, 2, 1'b1, -400};
        vecs[31] = '{1'b1, 100, 2, 1'b1, -100};
        vecs[32] = '{1'b1, 800, 3, 1'b1, -100};
        vecs[33] = '{1'b0, 800, 0, 1'b0, -100};
        vecs[34] = '{1'b0, 800, 0, 1'b0, -100};
        vecs[35] = '{1'b1, 1000, 1, 1'b0, -100};

        rst_n     = 1'b0;
        enable    = 1'b0;
        sig_in    = '0;
        thr_lo    = 16'd200;
        thr_hi    = 16'd600;
        t_unlock  = 24'd3;
        t_lock    = 24'd4;
        ramp_step = 16'd300;
        ramp_min  = 16'hFC18;  // -1000
        ramp_max  = 16'd1000;

        #2;
        check_all("reset", 0, 0, 0);
        @(negedge clk_in);
        rst_n = 1'b1;

        for (int i = 0; i < 36; i++) begin
            enable = vecs[i].en;
            step_edge(vecs[i].sig);
            check_all($sformatf("vec%0d", i), vecs[i].st, int'(vecs[i].rl), vecs[i].rp);
        end

        // Async reset mid-sweep: outputs return to reset values without a clock edge.
        t_unlock = 24'd0;
        step_edge(100);
        check_all("unlock0", 2, 1, -100);
        step_edge(100);
        check_all("sweep", 2, 1, 200);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("midreset", 0, 0, 0);
        @(negedge clk_in);
        rst_n = 1'b1;

        // Zero thresholds: single-sample unlock and lock.
        t_lock = 24'd0;
        enable = 1'b1;
        step_edge(1000);
        check_all("relock idle", 1, 0, 0);
        step_edge(100);
        check_all("fast unlock", 2, 1, 0);
        step_edge(800);
        check_all("fast lock", 1, 0, 0);

        // Degenerate range pins the ramp to ramp_min.
        ramp_min = 16'd50;
        ramp_max = 16'd50;
        step_edge(100);
        check_all("pin entry", 2, 1, 0);
        for (int k = 0; k < 3; k++) begin
            step_edge(100);
            check_all($sformatf("pin%0d", k), 2, 1, 50);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
